// File: rtl/rvee_trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// rvee_trap_ctrl_if
//
// Purpose:
//   Bundles every signal exchanged between the trap controller and the rest of
//   the core (pipeline, CSR file, fetch unit). The controller connects through
//   the slave modport. The core-side logic (or a testbench) uses the master
//   modport.
//
// Signal summary (direction as seen by the trap controller / slave):
//   exc_valid      in   synchronous exception from the pipeline
//   exc_cause      in   exception code [3:0]
//   exc_pc         in   faulting PC
//   exc_tval       in   trap value for mtval
//   irq_msip       in   machine software interrupt line (level)
//   irq_mtip       in   machine timer interrupt line (level)
//   irq_meip       in   machine external interrupt line (level)
//   mstatus_mie    in   global interrupt enable
//   mie_en         in   {MEIE, MTIE, MSIE}
//   mret_valid     in   MRET executed
//   mtvec, mepc    in   CSR values
//   next_pc        in   PC of the oldest unretired instruction
//   pipe_idle      in   pipeline drained
//   stall          out  hold fetch/issue
//   trap_req       out  one-cycle trap-entry strobe for the CSR file
//   trap_irq       out  cause is an interrupt
//   trap_cause     out  cause code [3:0]
//   trap_pc        out  value for mepc
//   tval_we        out  mtval write strobe
//   tval           out  mtval value
//   mret_restore   out  one-cycle strobe, mie <= mpie
//   redirect_valid out  one-cycle PC redirect
//   redirect_pc    out  redirect target
// -----------------------------------------------------------------------------
interface rvee_trap_ctrl_if #(
  parameter int XLEN = 32
);

  logic            exc_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc;
  logic [XLEN-1:0] exc_tval;
  logic            irq_msip;
  logic            irq_mtip;
  logic            irq_meip;
  logic            mstatus_mie;
  logic [2:0]      mie_en;
  logic            mret_valid;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] next_pc;
  logic            pipe_idle;

  logic            stall;
  logic            trap_req;
  logic            trap_irq;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            tval_we;
  logic [XLEN-1:0] tval;
  logic            mret_restore;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Core side: drives pipeline events and CSR values, consumes trap controls.
  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval,
    output irq_msip, irq_mtip, irq_meip, mstatus_mie, mie_en,
    output mret_valid, mtvec, mepc, next_pc, pipe_idle,
    input  stall, trap_req, trap_irq, trap_cause, trap_pc,
    input  tval_we, tval, mret_restore, redirect_valid, redirect_pc
  );

  // Trap controller side.
  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval,
    input  irq_msip, irq_mtip, irq_meip, mstatus_mie, mie_en,
    input  mret_valid, mtvec, mepc, next_pc, pipe_idle,
    output stall, trap_req, trap_irq, trap_cause, trap_pc,
    output tval_we, tval, mret_restore, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/rvee_trap_ctrl.sv
// -----------------------------------------------------------------------------
// rvee_trap_ctrl
//
// Purpose:
//   Machine-mode trap sequencer. It arbitrates between synchronous exceptions,
//   the three machine interrupts and MRET. It stalls the front end while the
//   pipeline drains for an interrupt, strobes the CSR file on trap entry and
//   issues the PC redirect.
//
//   Priority: exception > MEI (11) > MSI (3) > MTI (7) > MRET.
//
//   State flow:
//     IDLE   --exc-->  COMMIT --> REDIRECT --> IDLE
//     IDLE   --irq-->  DRAIN --pipe_idle--> COMMIT --> REDIRECT --> IDLE
//                      (COMMIT returns straight to IDLE if the interrupt is gone)
//     IDLE   --mret--> REDIRECT --> IDLE
//
// Ports:
//   clk      in  clock, all state updates on the rising edge
//   rst      in  synchronous, active-high reset
//   trap_if  slave modport of rvee_trap_ctrl_if (see that file for signals)
//
// Configuration:
//   RVEE_TRAP_VECTORED_EN - when defined and mtvec[1:0] == 2'b01, interrupt
//   redirects go to base + 4*cause. Exceptions and MRET always use the base
//   (or mepc). When undefined, mtvec[1:0] is ignored entirely.
// -----------------------------------------------------------------------------
module rvee_trap_ctrl #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  rvee_trap_ctrl_if.slave trap_if
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  state_t          r_state;
  state_t          w_next_state;

  // Latched trap context. r_is_irq / r_is_mret select how REDIRECT forms the
  // target address.
  logic [3:0]      r_cause;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tval;
  logic            r_is_irq;
  logic            r_is_mret;

  logic [3:0]      w_cause_d;
  logic [XLEN-1:0] w_pc_d;
  logic [XLEN-1:0] w_tval_d;
  logic            w_is_irq_d;
  logic            w_is_mret_d;

  logic [2:0]      w_irq_lines;
  logic            w_irq_pending;
  logic [3:0]      w_irq_cause;

  logic            w_trap_req;
  logic            w_tval_we;
  logic            w_mret_restore;
  logic            w_redirect_valid;
  logic [XLEN-1:0] w_redirect_pc;
  logic [3:0]      w_trap_cause;

  logic [XLEN-1:0] w_mtvec_base;
  logic [XLEN-1:0] w_trap_target;

  // Enabled, pending interrupt lines in {MEI, MTI, MSI} order. The cause
  // select follows MEI > MSI > MTI, which is not the bit order.
  assign w_irq_lines   = {trap_if.irq_meip, trap_if.irq_mtip, trap_if.irq_msip} & trap_if.mie_en;
  assign w_irq_pending = trap_if.mstatus_mie & (|w_irq_lines);

  always_comb begin
    w_irq_cause = CAUSE_MTI;
    if (w_irq_lines[2]) begin
      w_irq_cause = CAUSE_MEI;
    end else if (w_irq_lines[0]) begin
      w_irq_cause = CAUSE_MSI;
    end
  end

  // Trap target address. The low two mtvec bits are the mode field and never
  // part of the address.
  assign w_mtvec_base = {trap_if.mtvec[XLEN-1:2], 2'b00};

`ifdef RVEE_TRAP_VECTORED_EN
  always_comb begin
    w_trap_target = w_mtvec_base;
    if (r_is_irq && (trap_if.mtvec[1:0] == 2'b01)) begin
      w_trap_target = w_mtvec_base + {{(XLEN-6){1'b0}}, r_cause, 2'b00};
    end
  end
`else
  logic [1:0] w_unused_mtvec_mode;
  assign w_unused_mtvec_mode = trap_if.mtvec[1:0];
  assign w_trap_target       = w_mtvec_base;
`endif

  // State and trap-context registers. Reset clears everything, so a reset
  // taken in DRAIN or COMMIT discards the pending trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cause   <= '0;
      r_pc      <= '0;
      r_tval    <= '0;
      r_is_irq  <= 1'b0;
      r_is_mret <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cause   <= w_cause_d;
      r_pc      <= w_pc_d;
      r_tval    <= w_tval_d;
      r_is_irq  <= w_is_irq_d;
      r_is_mret <= w_is_mret_d;
    end
  end

  // Next-state logic, context capture and strobe generation. Each strobe is
  // tied to a single-cycle state (COMMIT, REDIRECT) or to the IDLE->REDIRECT
  // transition. That makes back-to-back pulses impossible.
  always_comb begin
    w_next_state     = r_state;
    w_cause_d        = r_cause;
    w_pc_d           = r_pc;
    w_tval_d         = r_tval;
    w_is_irq_d       = r_is_irq;
    w_is_mret_d      = r_is_mret;
    w_trap_req       = 1'b0;
    w_tval_we        = 1'b0;
    w_mret_restore   = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = '0;
    w_trap_cause     = r_cause;

    case (r_state)
      IDLE: begin
        if (trap_if.exc_valid) begin
          w_cause_d    = trap_if.exc_cause;
          w_pc_d       = trap_if.exc_pc;
          w_tval_d     = trap_if.exc_tval;
          w_is_irq_d   = 1'b0;
          w_is_mret_d  = 1'b0;
          w_next_state = COMMIT;
        end else if (w_irq_pending) begin
          w_is_irq_d   = 1'b1;
          w_is_mret_d  = 1'b0;
          w_next_state = DRAIN;
        end else if (trap_if.mret_valid) begin
          w_mret_restore = 1'b1;
          w_is_irq_d     = 1'b0;
          w_is_mret_d    = 1'b1;
          w_next_state   = REDIRECT;
        end
      end

      // A late exception still outranks the interrupt that is being drained.
      DRAIN: begin
        if (trap_if.exc_valid) begin
          w_cause_d    = trap_if.exc_cause;
          w_pc_d       = trap_if.exc_pc;
          w_tval_d     = trap_if.exc_tval;
          w_is_irq_d   = 1'b0;
          w_next_state = COMMIT;
        end else if (trap_if.pipe_idle) begin
          w_cause_d    = w_irq_cause;
          w_pc_d       = trap_if.next_pc;
          w_tval_d     = '0;
          w_is_irq_d   = 1'b1;
          w_next_state = COMMIT;
        end
      end

      // Level interrupts may have dropped or changed while draining. The cause
      // is re-evaluated here, and the trap is abandoned if nothing is pending.
      COMMIT: begin
        if (!r_is_irq) begin
          w_trap_req   = 1'b1;
          w_tval_we    = 1'b1;
          w_next_state = REDIRECT;
        end else if (w_irq_pending) begin
          w_trap_req   = 1'b1;
          w_trap_cause = w_irq_cause;
          w_cause_d    = w_irq_cause;
          w_next_state = REDIRECT;
        end else begin
          w_next_state = IDLE;
        end
      end

      REDIRECT: begin
        w_redirect_valid = 1'b1;
        w_redirect_pc    = r_is_mret ? trap_if.mepc : w_trap_target;
        w_next_state     = IDLE;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    // No strobe may escape in the cycle reset is applied.
    if (rst) begin
      w_trap_req       = 1'b0;
      w_tval_we        = 1'b0;
      w_mret_restore   = 1'b0;
      w_redirect_valid = 1'b0;
    end
  end

  assign trap_if.stall          = (r_state != IDLE);
  assign trap_if.trap_req       = w_trap_req;
  assign trap_if.trap_irq       = r_is_irq;
  assign trap_if.trap_cause     = w_trap_cause;
  assign trap_if.trap_pc        = r_pc;
  assign trap_if.tval_we        = w_tval_we;
  assign trap_if.tval           = r_tval;
  assign trap_if.mret_restore   = w_mret_restore;
  assign trap_if.redirect_valid = w_redirect_valid;
  assign trap_if.redirect_pc    = w_redirect_pc;

endmodule

// File: tb/tb_rvee_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rvee_trap_ctrl
//
// Purpose:
//   Self-checking bench for rvee_trap_ctrl. A table of single-event vectors
//   covers arbitration and redirect targets. Hand-written sequences cover the
//   multi-cycle cases: late pipe_idle, an interrupt dropped during drain, an
//   exception preempting a drain, and reset in COMMIT.
//   Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
//
// Configuration:
//   RVEE_TRAP_VECTORED_EN - selects the vectored-mode expectations.
// -----------------------------------------------------------------------------
module tb_rvee_trap_ctrl;

  localparam int XLEN = 32;

`ifdef RVEE_TRAP_VECTORED_EN
  localparam bit VECTORED_BUILD = 1'b1;
`else
  localparam bit VECTORED_BUILD = 1'b0;
`endif

  localparam int KIND_NONE = 0;
  localparam int KIND_EXC  = 1;
  localparam int KIND_IRQ  = 2;
  localparam int KIND_MRET = 3;
  localparam int NUM_VECS  = 10;

  typedef struct {
    logic        excValid;
    logic [3:0]  excCause;
    logic [31:0] excPc;
    logic [31:0] excTval;
    logic [2:0]  irqLines;
    logic        mie;
    logic [2:0]  mieEn;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] nextPc;
    int          kind;
    logic [3:0]  expCause;
    logic [31:0] expTrapPc;
    logic [31:0] expTval;
    logic [31:0] expRedirect;
  } vector_t;

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int errorCount = 0;

  vector_t vectors [NUM_VECS];

  always #5 clk = ~clk;

  rvee_trap_ctrl_if #(.XLEN(XLEN)) trapIf ();

  rvee_trap_ctrl #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst     (rst),
    .trap_if (trapIf)
  );

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearEvents();
    trapIf.exc_valid  = 1'b0;
    trapIf.mret_valid = 1'b0;
    trapIf.irq_meip   = 1'b0;
    trapIf.irq_mtip   = 1'b0;
    trapIf.irq_msip   = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v);
    trapIf.exc_valid   = v.excValid;
    trapIf.exc_cause   = v.excCause;
    trapIf.exc_pc      = v.excPc;
    trapIf.exc_tval    = v.excTval;
    trapIf.irq_meip    = v.irqLines[2];
    trapIf.irq_mtip    = v.irqLines[1];
    trapIf.irq_msip    = v.irqLines[0];
    trapIf.mstatus_mie = v.mie;
    trapIf.mie_en      = v.mieEn;
    trapIf.mret_valid  = v.mret;
    trapIf.mtvec       = v.mtvec;
    trapIf.mepc        = v.mepc;
    trapIf.next_pc     = v.nextPc;
    trapIf.pipe_idle   = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stall"}, trapIf.stall, 1'b0);
    checkOutput({tag, " trap_req"}, trapIf.trap_req, 1'b0);
    checkOutput({tag, " trap_irq"}, trapIf.trap_irq, 1'b0);
    checkWord({tag, " trap_cause"}, 32'(trapIf.trap_cause), 32'h0);
    checkWord({tag, " trap_pc"}, trapIf.trap_pc, 32'h0);
    checkOutput({tag, " tval_we"}, trapIf.tval_we, 1'b0);
    checkWord({tag, " tval"}, trapIf.tval, 32'h0);
    checkOutput({tag, " mret_restore"}, trapIf.mret_restore, 1'b0);
    checkOutput({tag, " redirect_valid"}, trapIf.redirect_valid, 1'b0);
    checkWord({tag, " redirect_pc"}, trapIf.redirect_pc, 32'h0);
  endtask

  // Apply one table vector from IDLE and follow it until IDLE is reached again.
  task automatic runVector(input vector_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    nextCycle();
    applyStimulus(v);
    @(negedge clk);
    checkOutput({tag, " idle stall"}, trapIf.stall, 1'b0);
    checkOutput({tag, " idle trap_req"}, trapIf.trap_req, 1'b0);
    checkOutput({tag, " mret_restore"}, trapIf.mret_restore, v.kind == KIND_MRET);

    case (v.kind)
      KIND_EXC: begin
        nextCycle();
        clearEvents();
        @(negedge clk);
        checkOutput({tag, " trap_req"}, trapIf.trap_req, 1'b1);
        checkOutput({tag, " trap_irq"}, trapIf.trap_irq, 1'b0);
        checkWord({tag, " trap_cause"}, 32'(trapIf.trap_cause), 32'(v.expCause));
        checkWord({tag, " trap_pc"}, trapIf.trap_pc, v.expTrapPc);
        checkOutput({tag, " tval_we"}, trapIf.tval_we, 1'b1);
        checkWord({tag, " tval"}, trapIf.tval, v.expTval);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " redirect_valid"}, trapIf.redirect_valid, 1'b1);
        checkWord({tag, " redirect_pc"}, trapIf.redirect_pc, v.expRedirect);
        checkOutput({tag, " redirect trap_req"}, trapIf.trap_req, 1'b0);
      end
      KIND_IRQ: begin
        nextCycle();
        trapIf.exc_valid  = 1'b0;
        trapIf.mret_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, " drain stall"}, trapIf.stall, 1'b1);
        checkOutput({tag, " drain trap_req"}, trapIf.trap_req, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput({tag, " trap_req"}, trapIf.trap_req, 1'b1);
        checkOutput({tag, " trap_irq"}, trapIf.trap_irq, 1'b1);
        checkWord({tag, " trap_cause"}, 32'(trapIf.trap_cause), 32'(v.expCause));
        checkWord({tag, " trap_pc"}, trapIf.trap_pc, v.expTrapPc);
        checkOutput({tag, " tval_we"}, trapIf.tval_we, 1'b0);
        nextCycle();
        clearEvents();
        @(negedge clk);
        checkOutput({tag, " redirect_valid"}, trapIf.redirect_valid, 1'b1);
        checkWord({tag, " redirect_pc"}, trapIf.redirect_pc, v.expRedirect);
      end
      KIND_MRET: begin
        nextCycle();
        clearEvents();
        @(negedge clk);
        checkOutput({tag, " redirect_valid"}, trapIf.redirect_valid, 1'b1);
        checkWord({tag, " redirect_pc"}, trapIf.redirect_pc, v.expRedirect);
        checkOutput({tag, " mret_restore 2nd"}, trapIf.mret_restore, 1'b0);
      end
      default: begin
        nextCycle();
        clearEvents();
        @(negedge clk);
        checkOutput({tag, " none stall"}, trapIf.stall, 1'b0);
        checkOutput({tag, " none redirect"}, trapIf.redirect_valid, 1'b0);
      end
    endcase

    nextCycle();
    clearEvents();
    @(negedge clk);
    checkOutput({tag, " end stall"}, trapIf.stall, 1'b0);
    checkOutput({tag, " end trap_req"}, trapIf.trap_req, 1'b0);
    checkOutput({tag, " end redirect"}, trapIf.redirect_valid, 1'b0);
  endtask

  initial begin
    int stallCycles;
    int trapPulses;
    int redirectPulses;
    logic [3:0]  seenCause;
    logic [31:0] seenPc;
    logic        seenIrq;
    logic        lastStall;

    // Field order:
    // excValid, excCause, excPc, excTval, irqLines{meip,mtip,msip}, mie, mieEn,
    // mret, mtvec, mepc, nextPc, kind, expCause, expTrapPc, expTval, expRedirect
    vectors[0] = '{1'b1, 4'd2, 32'h100, 32'hDEAD, 3'b000, 1'b1, 3'b111, 1'b0, 32'h800, 32'h204, 32'h300,
                   KIND_EXC, 4'd2, 32'h100, 32'hDEAD, 32'h800};
    vectors[1] = '{1'b1, 4'd5, 32'h140, 32'h1234, 3'b100, 1'b1, 3'b111, 1'b0, 32'h800, 32'h204, 32'h300,
                   KIND_EXC, 4'd5, 32'h140, 32'h1234, 32'h800};
    vectors[2] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b111, 1'b1, 3'b111, 1'b0, 32'h1001, 32'h204, 32'h300,
                   KIND_IRQ, 4'd11, 32'h300, 32'h0, VECTORED_BUILD ? 32'h102C : 32'h1000};
    vectors[3] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b011, 1'b1, 3'b111, 1'b0, 32'h800, 32'h204, 32'h310,
                   KIND_IRQ, 4'd3, 32'h310, 32'h0, 32'h800};
    vectors[4] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b010, 1'b1, 3'b010, 1'b0, 32'h801, 32'h204, 32'h320,
                   KIND_IRQ, 4'd7, 32'h320, 32'h0, VECTORED_BUILD ? 32'h81C : 32'h800};
    vectors[5] = '{1'b1, 4'd1, 32'h180, 32'hBEEF, 3'b000, 1'b1, 3'b111, 1'b0, 32'h801, 32'h204, 32'h300,
                   KIND_EXC, 4'd1, 32'h180, 32'hBEEF, 32'h800};
    vectors[6] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b100, 1'b1, 3'b011, 1'b1, 32'h801, 32'h204, 32'h300,
                   KIND_MRET, 4'd0, 32'h0, 32'h0, 32'h204};
    vectors[7] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b001, 1'b0, 3'b111, 1'b0, 32'h800, 32'h204, 32'h300,
                   KIND_NONE, 4'd0, 32'h0, 32'h0, 32'h0};
    vectors[8] = '{1'b0, 4'd0, 32'h0, 32'h0, 3'b010, 1'b1, 3'b111, 1'b1, 32'h900, 32'h204, 32'h330,
                   KIND_IRQ, 4'd7, 32'h330, 32'h0, 32'h900};
    vectors[9] = '{1'b1, 4'd13, 32'h1C0, 32'h42, 3'b000, 1'b1, 3'b111, 1'b1, 32'h800, 32'h204, 32'h300,
                   KIND_EXC, 4'd13, 32'h1C0, 32'h42, 32'h800};

    // Reset with quiet inputs.
    rst = 1'b1;
    applyStimulus(vectors[7]);
    clearEvents();
    trapIf.mstatus_mie = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    for (int i = 0; i < NUM_VECS; i++) begin
      runVector(vectors[i], i);
    end

    // MTIP+MSIP with pipe_idle arriving on the third drain cycle.
    nextCycle();
    trapIf.mtvec       = 32'h800;
    trapIf.next_pc     = 32'h4440;
    trapIf.mstatus_mie = 1'b1;
    trapIf.mie_en      = 3'b111;
    trapIf.irq_mtip    = 1'b1;
    trapIf.irq_msip    = 1'b1;
    trapIf.pipe_idle   = 1'b0;
    @(negedge clk);
    checkOutput("late idle first stall", trapIf.stall, 1'b0);
    stallCycles = 0;
    trapPulses  = 0;
    seenCause   = 4'd0;
    seenPc      = 32'h0;
    seenIrq     = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      nextCycle();
      trapIf.pipe_idle = (cyc >= 3);
      if (cyc == 5) clearEvents();
      @(negedge clk);
      if (trapIf.stall) stallCycles++;
      if (trapIf.trap_req) begin
        trapPulses++;
        seenCause = trapIf.trap_cause;
        seenPc    = trapIf.trap_pc;
        seenIrq   = trapIf.trap_irq;
      end
    end
    checkWord("late idle stall cycles", 32'(stallCycles), 32'd5);
    checkWord("late idle trap pulses", 32'(trapPulses), 32'd1);
    checkWord("late idle cause", 32'(seenCause), 32'd3);
    checkWord("late idle trap_pc", seenPc, 32'h4440);
    checkOutput("late idle trap_irq", seenIrq, 1'b1);

    // MEIP raised, then dropped while draining: no trap, stall released.
    nextCycle();
    trapIf.irq_meip  = 1'b1;
    trapIf.pipe_idle = 1'b0;
    @(negedge clk);
    trapPulses     = 0;
    redirectPulses = 0;
    lastStall      = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      nextCycle();
      if (cyc == 2) trapIf.irq_meip = 1'b0;
      trapIf.pipe_idle = (cyc >= 3);
      @(negedge clk);
      if (trapIf.trap_req) trapPulses++;
      if (trapIf.redirect_valid) redirectPulses++;
      if (cyc == 2) checkOutput("drop irq drain stall", trapIf.stall, 1'b1);
      lastStall = trapIf.stall;
    end
    checkWord("drop irq trap pulses", 32'(trapPulses), 32'd0);
    checkWord("drop irq redirect pulses", 32'(redirectPulses), 32'd0);
    checkOutput("drop irq stall released", lastStall, 1'b0);

    // Exception arriving mid-drain preempts the interrupt. exc_valid held into
    // COMMIT/REDIRECT with a different cause must be ignored.
    nextCycle();
    trapIf.irq_mtip  = 1'b1;
    trapIf.pipe_idle = 1'b0;
    @(negedge clk);
    nextCycle();
    @(negedge clk);
    checkOutput("preempt drain stall", trapIf.stall, 1'b1);
    nextCycle();
    trapIf.exc_valid = 1'b1;
    trapIf.exc_cause = 4'd4;
    trapIf.exc_pc    = 32'h500;
    trapIf.exc_tval  = 32'h77;
    @(negedge clk);
    checkOutput("preempt no early trap", trapIf.trap_req, 1'b0);
    nextCycle();
    trapIf.exc_cause = 4'd9;
    trapIf.exc_pc    = 32'h900;
    trapIf.irq_mtip  = 1'b0;
    @(negedge clk);
    checkOutput("preempt trap_req", trapIf.trap_req, 1'b1);
    checkOutput("preempt trap_irq", trapIf.trap_irq, 1'b0);
    checkWord("preempt cause", 32'(trapIf.trap_cause), 32'd4);
    checkWord("preempt trap_pc", trapIf.trap_pc, 32'h500);
    checkOutput("preempt tval_we", trapIf.tval_we, 1'b1);
    checkWord("preempt tval", trapIf.tval, 32'h77);
    nextCycle();
    @(negedge clk);
    checkOutput("preempt redirect_valid", trapIf.redirect_valid, 1'b1);
    checkWord("preempt redirect_pc", trapIf.redirect_pc, 32'h800);
    nextCycle();
    trapIf.exc_valid = 1'b0;
    trapIf.pipe_idle = 1'b1;
    @(negedge clk);
    checkOutput("preempt back idle", trapIf.stall, 1'b0);
    checkOutput("preempt no retrap", trapIf.trap_req, 1'b0);

    // Reset asserted while in COMMIT.
    nextCycle();
    trapIf.exc_valid = 1'b1;
    trapIf.exc_cause = 4'd6;
    trapIf.exc_pc    = 32'h600;
    trapIf.exc_tval  = 32'h66;
    @(negedge clk);
    nextCycle();
    trapIf.exc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst commit trap_req", trapIf.trap_req, 1'b0);
    checkOutput("rst commit tval_we", trapIf.tval_we, 1'b0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("rst commit after");
    nextCycle();
    @(negedge clk);
    checkOutput("rst commit no redirect", trapIf.redirect_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rvee_trap_ctrl.md
RVEE_TRAP_CTRL -- requirements
Module: rvee_trap_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/PC width.
REQ-002 SHALL have `clk  in  1`: clock; all state updates on its rising edge.
REQ-003 SHALL have `rst  in  1`: reset, synchronous, active-high.
REQ-004 SHALL have `exc_valid  in  1`: synchronous exception from the pipeline.
REQ-005 SHALL have `exc_cause  in  4`: exception code.
REQ-006 SHALL have `exc_pc  in  XLEN`: faulting PC.
REQ-007 SHALL have `exc_tval  in  XLEN`: trap value.
REQ-008 SHALL have `irq_msip, irq_mtip, irq_meip  in  1 each`: level interrupt lines.
REQ-009 SHALL have `mstatus_mie  in  1`: global enable.
REQ-010 SHALL have `mie_en  in  3`: {MEIE, MTIE, MSIE}.
REQ-011 SHALL have `mret_valid  in  1`: MRET executed.
REQ-012 SHALL have `mtvec, mepc  in  XLEN`: CSR values.
REQ-013 SHALL have `next_pc  in  XLEN`: PC of the oldest unretired instruction.
REQ-014 SHALL have `pipe_idle  in  1`: pipeline drained.
REQ-015 SHALL have `stall  out  1`: hold fetch/issue.
REQ-016 SHALL have `trap_req  out  1`: one-cycle CSR trap-entry strobe (mepc/mcause/mpie update).
REQ-017 SHALL have `trap_irq  out  1`: cause is an interrupt.
REQ-018 SHALL have `trap_cause  out  4`: cause code.
REQ-019 SHALL have `trap_pc  out  XLEN`: value for mepc.
REQ-020 SHALL have `tval_we  out  1`: mtval write strobe.
REQ-021 SHALL have `tval  out  XLEN`: mtval value.
REQ-022 SHALL have `mret_restore  out  1`: one-cycle strobe, mie<=mpie.
REQ-023 SHALL have `redirect_valid  out  1`: one-cycle PC redirect.
REQ-024 SHALL have `redirect_pc  out  XLEN`: redirect target.

Function
REQ-025 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-026 Interrupt pending SHALL be mstatus_mie & |({meip,mtip,msip} & mie_en).
REQ-027 Priority SHALL be exception > MEI (cause 11) > MSI (cause 3) > MTI (cause 7) > MRET.
REQ-028 IDLE + exc_valid SHALL go to COMMIT, latching cause, pc and tval.
REQ-029 Latency: exc_valid at cycle N SHALL give trap_req at N+1 and redirect_valid at N+2.
REQ-030 IDLE + interrupt pending (no exception) SHALL go to DRAIN with stall=1.
REQ-031 DRAIN SHALL wait for pipe_idle, then go to COMMIT, latching next_pc as trap_pc.
REQ-032 In COMMIT, the interrupt SHALL be re-evaluated.
REQ-033 If the interrupt is no longer pending in COMMIT, SHALL return to IDLE with no trap_req.
REQ-034 COMMIT SHALL pulse trap_req; for exceptions only, it SHALL also pulse tval_we.
REQ-035 COMMIT SHALL then go to REDIRECT.
REQ-036 Without the configured vectored mode, REDIRECT SHALL pulse redirect_valid with {mtvec[XLEN-1:2],2'b00}, then go to IDLE.
REQ-037 IDLE + mret_valid (nothing higher priority) SHALL pulse mret_restore and go to REDIRECT with redirect_pc=mepc.
REQ-038 stall SHALL be 1 in every state except IDLE.
REQ-039 An exc_valid arriving during DRAIN SHALL preempt the interrupt and go to COMMIT as an exception.
REQ-040 exc_valid and mret_valid outside IDLE/DRAIN SHALL be ignored.
REQ-041 Strobe outputs SHALL never be high two consecutive cycles.

Reset
REQ-042 rst SHALL force IDLE.
REQ-043 rst SHALL zero all outputs and latched cause/pc/tval next cycle, including mid-DRAIN or mid-COMMIT, with no trap_req emitted.

Configuration
REQ-044 With RVEE_TRAP_VECTORED_EN defined and mtvec[1:0]==01, interrupt redirects SHALL target base+4*cause, while exceptions and MRET are unchanged.
REQ-045 Without RVEE_TRAP_VECTORED_EN, mtvec[1:0] SHALL be ignored and all traps SHALL go to the base address.

Verification
REQ-046 exc_valid, cause 2, pc 0x100, tval 0xDEAD -> trap_req N+1 with cause 2, irq 0, tval_we 1; redirect N+2 to mtvec 0x800.
REQ-047 MTIP+MSIP, mie_en=3'b111, mie=1, pipe_idle late by 3 cycles -> stall 5 cycles; cause 3, trap_pc=next_pc.
REQ-048 MEIP raised then dropped during DRAIN -> no trap_req; return to IDLE, stall released.
REQ-049 mret_valid, mepc 0x204 -> mret_restore 1 cycle, redirect_pc 0x204 next cycle.
REQ-050 VECTORED_EN, mtvec 0x801, MTIP -> redirect 0x81C; exception still goes to 0x800.
REQ-051 rst asserted in COMMIT -> IDLE, all outputs 0, no strobes.
